// File: rtl/vip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vip_pkg
//  Description : Shared types and constants for the VIP bus master slice:
//                access-size encoding, bus-master FSM states and the default
//                watchdog limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package vip_pkg;

   // Default number of cycles a transaction may take before the watchdog fires
   localparam int unsigned C_TIMEOUT_CYCLES = 64;

   // Access size as encoded on the command interface
   typedef enum logic [1:0] {
      SIZE_B   = 2'd0,
      SIZE_H   = 2'd1,
      SIZE_W   = 2'd2,
      SIZE_BAD = 2'd3
   } size_e;

   // Bus-master sequencing states
   typedef enum logic [1:0] {
      BM_IDLE = 2'd0,
      BM_ADDR = 2'd1,
      BM_RESP = 2'd2,
      BM_ERR  = 2'd3
   } bm_state_e;

endpackage : vip_pkg
`default_nettype wire

// File: rtl/vip_bus_align.sv
`default_nettype none
// ============================================================================
//  Module      : vip_bus_align
//  Description : Purely combinational lane logic for the bus master. The
//                encode side turns a command (size, byte offset, right-aligned
//                data) into byte enables, lane-replicated write data and a
//                misalignment flag. The extract side shifts returned read data
//                down by the byte offset and zero/sign-extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_bus_align
   import vip_pkg::*;
(
   input  size_e       enc_size_i,
   input  logic [1:0]  enc_off_i,
   input  logic [31:0] enc_wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o,
   input  size_e       ext_size_i,
   input  logic [1:0]  ext_off_i,
   input  logic        ext_signed_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] rdata_o
);

   logic [31:0] w_shifted;

   // Selected lanes move down to bit 0 before extension
   assign w_shifted = rdata_i >> {ext_off_i, 3'b000};

   // Byte enables, write-data replication and alignment check for a new command
   always_comb begin
      be_o         = 4'b0000;
      wdata_o      = enc_wdata_i;
      misaligned_o = 1'b0;
      case (enc_size_i)
         SIZE_B: begin
            be_o    = 4'b0001 << enc_off_i;
            wdata_o = {4{enc_wdata_i[7:0]}};
         end
         SIZE_H: begin
            be_o         = enc_off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o      = {2{enc_wdata_i[15:0]}};
            misaligned_o = enc_off_i[0];
         end
         SIZE_W: begin
            be_o         = 4'b1111;
            misaligned_o = |enc_off_i;
         end
         default: begin
            misaligned_o = 1'b1;
         end
      endcase
   end

   // Zero- or sign-extension of the shifted read data
   always_comb begin
      rdata_o = w_shifted;
      case (ext_size_i)
         SIZE_B:  rdata_o = {{24{ext_signed_i & w_shifted[7]}},  w_shifted[7:0]};
         SIZE_H:  rdata_o = {{16{ext_signed_i & w_shifted[15]}}, w_shifted[15:0]};
         default: rdata_o = w_shifted;
      endcase
   end

endmodule : vip_bus_align
`default_nettype wire

// File: rtl/vip_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : vip_bus_master
//  Description : Bus initiator for the req/gnt/rvalid memory port. Accepts one
//                load/store command at a time, drives a protocol-correct bus
//                transaction and returns a single-cycle response carrying the
//                extracted load data or an error indication.
//  Options     : VIP_BUS_MASTER_TIMEOUT_EN - enables the transaction watchdog
//                (TIMEOUT_CYCLES / CNT_W). Without it rsp_timeout is tied low
//                and the block waits indefinitely for the responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_bus_master
   import vip_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk_sys,
   input  logic        rst_sys_n,
   // command side
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [1:0]  cmd_size,
   input  logic        cmd_signed,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   // response side
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_misaligned,
   output logic        rsp_timeout,
   // memory bus
   output logic        data_req,
   output logic        data_we,
   output logic [3:0]  data_be,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_gnt,
   input  logic        data_rvalid,
   input  logic [31:0] data_rdata
);

   bm_state_e   state_q,  state_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        we_q,     we_d;
   size_e       size_q,   size_d;
   logic        signed_q, signed_d;
   logic [1:0]  off_q,    off_d;
   logic        req_q,    req_d;
   logic        dwe_q,    dwe_d;
   logic [3:0]  be_q,     be_d;
   logic [31:0] daddr_q,  daddr_d;
   logic [31:0] dwdata_q, dwdata_d;
   logic        rvld_q,   rvld_d;
   logic [31:0] rdata_q,  rdata_d;
   logic        rmis_q,   rmis_d;
   logic        rto_q,    rto_d;

   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic        w_misaligned;
   logic [31:0] w_ext;
   logic        w_timeout_hit;

   vip_bus_align u_align (
      .enc_size_i   (size_e'(cmd_size)),
      .enc_off_i    (cmd_addr[1:0]),
      .enc_wdata_i  (cmd_wdata),
      .be_o         (w_be),
      .wdata_o      (w_wdata),
      .misaligned_o (w_misaligned),
      .ext_size_i   (size_q),
      .ext_off_i    (off_q),
      .ext_signed_i (signed_q),
      .rdata_i      (data_rdata),
      .rdata_o      (w_ext)
   );

`ifdef VIP_BUS_MASTER_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The limit is reached in the last permitted cycle of ADDR/RESP
   assign w_timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog count: restart on bus issue, advance while the bus is busy
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == BM_IDLE && state_d == BM_ADDR) begin
         cnt_d = '0;
      end else if (state_q == BM_ADDR || state_q == BM_RESP) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic w_unused_cfg;

   assign w_timeout_hit = 1'b0;
   assign w_unused_cfg  = ^{TIMEOUT_CYCLES, CNT_W};
`endif

   // Next-state, bus fields and response generation
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      size_d   = size_q;
      signed_d = signed_q;
      off_d    = off_q;
      req_d    = req_q;
      dwe_d    = dwe_q;
      be_d     = be_q;
      daddr_d  = daddr_q;
      dwdata_d = dwdata_q;
      rvld_d   = 1'b0;
      rdata_d  = '0;
      rmis_d   = 1'b0;
      rto_d    = 1'b0;

      case (state_q)
         BM_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               we_d     = cmd_we;
               size_d   = size_e'(cmd_size);
               signed_d = cmd_signed;
               off_d    = cmd_addr[1:0];
               if (w_misaligned) begin
                  state_d = BM_ERR;
                  rvld_d  = 1'b1;
                  rmis_d  = 1'b1;
               end else begin
                  state_d  = BM_ADDR;
                  req_d    = 1'b1;
                  dwe_d    = cmd_we;
                  be_d     = w_be;
                  daddr_d  = {cmd_addr[31:2], 2'b00};
                  dwdata_d = w_wdata;
               end
            end
         end
         BM_ADDR: begin
            if (data_gnt && data_rvalid) begin
               state_d = BM_IDLE;
               req_d   = 1'b0;
               rvld_d  = 1'b1;
               rdata_d = we_q ? '0 : w_ext;
            end else if (w_timeout_hit) begin
               state_d = BM_IDLE;
               req_d   = 1'b0;
               rvld_d  = 1'b1;
               rto_d   = 1'b1;
            end else if (data_gnt) begin
               state_d = BM_RESP;
               req_d   = 1'b0;
            end
         end
         BM_RESP: begin
            if (data_rvalid) begin
               state_d = BM_IDLE;
               rvld_d  = 1'b1;
               rdata_d = we_q ? '0 : w_ext;
            end else if (w_timeout_hit) begin
               state_d = BM_IDLE;
               rvld_d  = 1'b1;
               rto_d   = 1'b1;
            end
         end
         BM_ERR: begin
            state_d = BM_IDLE;
         end
         default: begin
            state_d = BM_IDLE;
         end
      endcase

      // Ready tracks the state being entered so it rises with rsp_valid
      cmd_ready_d = (state_d == BM_IDLE);
   end

   // State and output registers; everything clears on reset
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q     <= BM_IDLE;
         cmd_ready_q <= 1'b0;
         we_q        <= 1'b0;
         size_q      <= SIZE_B;
         signed_q    <= 1'b0;
         off_q       <= 2'b00;
         req_q       <= 1'b0;
         dwe_q       <= 1'b0;
         be_q        <= 4'b0000;
         daddr_q     <= '0;
         dwdata_q    <= '0;
         rvld_q      <= 1'b0;
         rdata_q     <= '0;
         rmis_q      <= 1'b0;
         rto_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         we_q        <= we_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         off_q       <= off_d;
         req_q       <= req_d;
         dwe_q       <= dwe_d;
         be_q        <= be_d;
         daddr_q     <= daddr_d;
         dwdata_q    <= dwdata_d;
         rvld_q      <= rvld_d;
         rdata_q     <= rdata_d;
         rmis_q      <= rmis_d;
         rto_q       <= rto_d;
      end
   end

   assign cmd_ready      = cmd_ready_q;
   assign rsp_valid      = rvld_q;
   assign rsp_rdata      = rdata_q;
   assign rsp_misaligned = rmis_q;
   assign rsp_timeout    = rto_q;
   assign data_req       = req_q;
   assign data_we        = dwe_q;
   assign data_be        = be_q;
   assign data_addr      = daddr_q;
   assign data_wdata     = dwdata_q;

endmodule : vip_bus_master
`default_nettype wire

// File: tb/tb_vip_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vip_bus_master
//  Description : Scoreboard bench for vip_bus_master with a RAM responder and
//                a byte-level reference memory. Define
//                VIP_BUS_MASTER_TIMEOUT_EN to also exercise the watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_bus_master;

   localparam int unsigned TO = 8;

   logic        clk_sys   = 1'b0;
   logic        rst_sys_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_we, cmd_signed;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_misaligned, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        data_req, data_we, data_gnt, data_rvalid;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;

   always #5 clk_sys = ~clk_sys;

   vip_bus_master #(.TIMEOUT_CYCLES(TO), .CNT_W($clog2(TO + 1))) dut (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_size(cmd_size), .cmd_signed(cmd_signed), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_misaligned(rsp_misaligned), .rsp_timeout(rsp_timeout),
      .data_req(data_req), .data_we(data_we), .data_be(data_be),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      logic        to;
      int          acc;
      int          lat;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } bus_t;

   rsp_t        rsp_q[$];
   bus_t        bus_q[$];
   logic [7:0]  mdl [1024];
   logic [31:0] ram [256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // ---------------- reference model (byte-addressed memory) ----------------
   function automatic logic model_bad(input logic [1:0] size, input logic [31:0] a);
      return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic int nbytes(input logic [1:0] size);
      return 1 << size;
   endfunction

   function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [31:0] a);
      logic [3:0] be = 4'b0000;
      for (int i = 0; i < nbytes(size); i++) be[(a + i) % 4] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] w);
      if (size == 2'd0) return {4{w[7:0]}};
      if (size == 2'd1) return {2{w[15:0]}};
      return w;
   endfunction

   function automatic void model_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < nbytes(size); i++) mdl[(a + i) % 1024] = w[8*i +: 8];
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn, input logic [31:0] a);
      logic [31:0] v = 32'h0;
      int n = nbytes(size);
      for (int i = 0; i < n; i++) v = v | (32'(mdl[(a + i) % 1024]) << (8 * i));
      if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   // ---------------- RAM responder ----------------
   bit          stall_all = 0;
   bit          pulse     = 0;
   int          fixed_lat = 0;
   int          max_wait  = 0;
   int          wait_cnt, pend_cnt;
   logic [31:0] pend_data;

   always @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         data_gnt    <= 1'b0;
         data_rvalid <= 1'b0;
         data_rdata  <= 32'h0;
         wait_cnt    <= 0;
         pend_cnt    <= 0;
         pend_data   <= 32'h0;
      end else begin
         data_gnt    <= 1'b0;
         data_rvalid <= 1'b0;
         if (pulse) begin
            data_gnt    <= 1'b1;
            data_rvalid <= 1'b1;
            data_rdata  <= 32'hBAD0_BAD0;
         end else if (pend_cnt > 0) begin
            if (pend_cnt == 1) begin
               data_rvalid <= 1'b1;
               data_rdata  <= pend_data;
            end
            pend_cnt <= pend_cnt - 1;
         end else if (data_req && !data_gnt && !stall_all) begin
            if (wait_cnt > 0) begin
               wait_cnt <= wait_cnt - 1;
            end else begin
               data_gnt <= 1'b1;
               wait_cnt <= (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
               if (data_we)
                  for (int l = 0; l < 4; l++)
                     if (data_be[l]) ram[data_addr[9:2]][8*l +: 8] <= data_wdata[8*l +: 8];
               if (fixed_lat == 0 || (fixed_lat < 0 && $urandom_range(0, 1) == 0)) begin
                  data_rvalid <= 1'b1;
                  data_rdata  <= ram[data_addr[9:2]];
               end else begin
                  pend_cnt  <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
                  pend_data <= ram[data_addr[9:2]];
               end
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   always @(negedge clk_sys) begin : rsp_mon
      rsp_t e;
      if (rsp_valid) begin
         if (rsp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_rsp: got rsp_valid rdata=%08h mis=%0b to=%0b expected no response",
                     rsp_rdata, rsp_misaligned, rsp_timeout);
         end else begin
            e = rsp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_misaligned", {31'b0, rsp_misaligned}, {31'b0, e.mis});
            check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
            if (e.lat >= 0) check("rsp_latency", cyc - e.acc, e.lat);
         end
      end
   end

   // ---------------- bus monitor ----------------
   logic prev_req = 1'b0;
   bus_t cur;

   always @(negedge clk_sys) begin : bus_mon
      if (data_req && !prev_req) begin
         if (bus_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_req: got data_req=1 addr=%08h expected no bus activity", data_addr);
         end else begin
            cur = bus_q.pop_front();
            check("data_addr", data_addr, cur.addr);
            check("data_be", {28'b0, data_be}, {28'b0, cur.be});
            check("data_wdata", data_wdata, cur.wdata);
            check("data_we", {31'b0, data_we}, {31'b0, cur.we});
         end
      end else if (data_req && prev_req) begin
         check("bus_stable_addr", data_addr, cur.addr);
         check("bus_stable_wdata", data_wdata ^ {28'b0, data_be}, cur.wdata ^ {28'b0, cur.be});
      end
      prev_req = data_req;
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input bit push_rsp, input bit exp_to);
      int   n = 0;
      rsp_t e;
      bus_t b;
      logic bad;
      @(negedge clk_sys);
      while (!cmd_ready && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      if (!cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL cmd_ready_wait: got cmd_ready=0 for 100 cycles expected 1");
         return;
      end
      cmd_valid  = 1'b1;
      cmd_we     = we;
      cmd_size   = size;
      cmd_signed = sgn;
      cmd_addr   = addr;
      cmd_wdata  = wdata;
      bad        = model_bad(size, addr);
      e.acc   = cyc;
      e.lat   = lat;
      e.mis   = bad;
      e.to    = exp_to;
      e.rdata = 32'h0;
      if (!bad) begin
         b.addr  = {addr[31:2], 2'b00};
         b.be    = exp_be(size, addr);
         b.wdata = exp_wdata(size, wdata);
         b.we    = we;
         bus_q.push_back(b);
         if (!exp_to) begin
            if (we) model_store(size, addr, wdata);
            else    e.rdata = model_load(size, sgn, addr);
         end
      end
      if (push_rsp) rsp_q.push_back(e);
      @(posedge clk_sys);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      @(negedge clk_sys);
      if (rsp_q.size() != 0 || bus_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d responses and %0d bus items outstanding expected 0",
                  rsp_q.size(), bus_q.size());
         rsp_q.delete();
         bus_q.delete();
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      cmd_valid  = 1'b0;
      cmd_we     = 1'b0;
      cmd_size   = 2'd0;
      cmd_signed = 1'b0;
      cmd_addr   = 32'h0;
      cmd_wdata  = 32'h0;
      for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
      for (int i = 0; i < 256; i++)  ram[i] = 32'h0;

      // reset state
      repeat (3) @(negedge clk_sys);
      check("reset_ctrl", {22'b0, cmd_ready, rsp_valid, rsp_misaligned, rsp_timeout,
                           data_req, data_we, data_be}, 32'h0);
      check("reset_rsp_rdata", rsp_rdata, 32'h0);
      check("reset_data_addr", data_addr, 32'h0);
      check("reset_data_wdata", data_wdata, 32'h0);
      rst_sys_n = 1'b1;
      #1;
      check("ready_before_clk", {31'b0, cmd_ready}, 32'h0);
      @(negedge clk_sys);
      check("ready_after_clk", {31'b0, cmd_ready}, 32'h1);

      // directed: word store, byte loads, half store, misaligned/illegal
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 3, 1'b1, 1'b0);
      drain();
      check("ram_word_store", ram[8'h40], 32'hDEAD_BEEF);
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_1234, 3, 1'b1, 1'b0);
      issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 3, 1'b1, 1'b0);
      issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 3, 1'b1, 1'b0);
      issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_ABCD, 3, 1'b1, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 1'b1, 1'b0);
      drain();
      check("ram_half_store", ram[8'h40], 32'hABCD_1234);
      issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1, 1'b1, 1'b0);
      issue(1'b1, 2'd3, 1'b0, 32'h100, 32'h1111_1111, 1, 1'b1, 1'b0);
      issue(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 1, 1'b1, 1'b0);
      issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 3, 1'b1, 1'b0);
      drain();

`ifdef VIP_BUS_MASTER_TIMEOUT_EN
      // watchdog: responder never grants, then a late grant pulse
      begin
         int n = 0;
         stall_all = 1;
         issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, int'(TO) + 1, 1'b1, 1'b1);
         while (!rsp_valid && n < 50) begin
            @(negedge clk_sys);
            n++;
         end
         check("timeout_data_req", {31'b0, data_req}, 32'h0);
         repeat (2) @(negedge clk_sys);
         pulse = 1;
         @(posedge clk_sys);
         #1;
         pulse = 0;
         repeat (6) @(negedge clk_sys);
         stall_all = 0;
         drain();
      end
`endif

      // randomized traffic against the reference model
      fixed_lat = -1;
      max_wait  = 1;
      for (int k = 0; k < 150; k++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_sys);
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, -1, 1'b1, 1'b0);
      end
      drain();

      // reset while waiting for rvalid: abandon the command silently
      fixed_lat = 6;
      max_wait  = 0;
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, -1, 1'b0, 1'b0);
      begin
         int n = 0;
         while (!data_req && n < 20) begin
            @(negedge clk_sys);
            n++;
         end
         while (data_req && n < 20) begin
            @(negedge clk_sys);
            n++;
         end
      end
      rst_sys_n = 1'b0;
      #1;
      check("midrst_ctrl", {22'b0, cmd_ready, rsp_valid, rsp_misaligned, rsp_timeout,
                            data_req, data_we, data_be}, 32'h0);
      check("midrst_data_addr", data_addr, 32'h0);
      check("midrst_rsp_rdata", rsp_rdata, 32'h0);
      repeat (2) @(negedge clk_sys);
      rst_sys_n = 1'b1;
      @(negedge clk_sys);
      check("midrst_ready", {31'b0, cmd_ready}, 32'h1);
      repeat (12) @(negedge clk_sys);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got simulation still running expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule : tb_vip_bus_master
`default_nettype wire
